// File: rtl/xor_checksum_ctrl.sv
// rtl/xor_checksum_ctrl.sv - folds a length-prefixed word burst into one XOR checksum
module xor_checksum_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [LEN_W-1:0] remaining,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] rem_q;

    // Every output is a pure decode of registered state, so no input reaches an output combinationally.
    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign out_data  = acc;
    assign remaining = rem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            rem_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= seed;
                        rem_q <= len;
                        state <= (len != '0) ? S_ACCUM : S_DONE;
                    end
                end
                S_ACCUM: begin
                    // ACCUM is only entered with a nonzero count, so this decrement cannot wrap.
                    if (in_valid) begin
                        acc   <= acc ^ in_data;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_checksum_ctrl.sv
// tb/tb_xor_checksum_ctrl.sv - directed self-checking bench for xor_checksum_ctrl
module tb_xor_checksum_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [7:0] len;
    logic       busy;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] remaining;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    xor_checksum_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .remaining (remaining),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'h00);
        check({tag, "_remaining"}, 32'(remaining), 32'd0);
    endtask

    int n_xfer;
    int exp_rem;

    initial begin
        rst_n = 1'b0; start = 1'b0; seed = 8'h00; len = 8'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // reset then idle
        tick(); tick();
        check_idle("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("idle");
        end

        // basic burst: 0x0F ^ 0xF0 ^ 0xAA = 0x55
        start = 1'b1; seed = 8'h00; len = 8'd3;
        tick();
        start = 1'b0;
        check("b_busy", 32'(busy), 32'd1);
        check("b_rem3", 32'(remaining), 32'd3);
        check("b_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h0F;
        tick();
        check("b_rem2", 32'(remaining), 32'd2);
        check("b_ov_early1", 32'(out_valid), 32'd0);
        in_data = 8'hF0;
        tick();
        check("b_rem1", 32'(remaining), 32'd1);
        in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        check("b_rem0", 32'(remaining), 32'd0);
        check("b_out_valid", 32'(out_valid), 32'd1);
        check("b_in_ready_off", 32'(in_ready), 32'd0);
        check("b_out_data", 32'(out_data), 32'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b_idle_busy", 32'(busy), 32'd0);
        check("b_idle_ov", 32'(out_valid), 32'd0);

        // zero length with back-pressure
        start = 1'b1; seed = 8'h3C; len = 8'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("z_out_valid", 32'(out_valid), 32'd1);
            check("z_out_data", 32'(out_data), 32'h3C);
            check("z_in_ready", 32'(in_ready), 32'd0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("z_idle_busy", 32'(busy), 32'd0);
        check("z_idle_ov", 32'(out_valid), 32'd0);

        // stalls and an ignored mid-burst start: 0xFF ^ 0x01 ^ 0x02 = 0xFC
        start = 1'b1; seed = 8'hFF; len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b0; in_data = 8'h77;
        tick();
        check("s_stall_rem", 32'(remaining), 32'd2);
        in_valid = 1'b1; in_data = 8'h01;
        start = 1'b1; seed = 8'h00; len = 8'd5;
        tick();
        start = 1'b0;
        check("s_rem1", 32'(remaining), 32'd1);
        in_valid = 1'b0; in_data = 8'h55;
        tick();
        tick();
        check("s_stall_rem1", 32'(remaining), 32'd1);
        check("s_stall_busy", 32'(busy), 32'd1);
        check("s_stall_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h02;
        tick();
        in_valid = 1'b0;
        check("s_out_valid", 32'(out_valid), 32'd1);
        check("s_out_data", 32'(out_data), 32'hFC);
        check("s_rem0", 32'(remaining), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("s_idle_busy", 32'(busy), 32'd0);

        // reset mid-burst, then a fresh burst: 0x11 ^ 0x22 = 0x33
        start = 1'b1; seed = 8'hA5; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        tick(); tick();
        check("r_rem2", 32'(remaining), 32'd2);
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        check_idle("r_mid");
        rst_n = 1'b1;
        tick();
        check_idle("r_after");
        start = 1'b1; seed = 8'h11; len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check("r_out_valid", 32'(out_valid), 32'd1);
        check("r_out_data", 32'(out_data), 32'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // max length: 255 words of 0x01 gives 0x01
        start = 1'b1; seed = 8'h00; len = 8'd255;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h01;
        n_xfer = 0;
        exp_rem = 255;
        for (int c = 0; c < 300 && !out_valid; c++) begin
            check("m_rem", 32'(remaining), 32'(exp_rem));
            if (in_ready) begin
                n_xfer++;
                exp_rem--;
            end
            tick();
        end
        check("m_out_valid", 32'(out_valid), 32'd1);
        check("m_xfers", 32'(n_xfer), 32'd255);
        check("m_rem0", 32'(remaining), 32'd0);
        check("m_in_ready_off", 32'(in_ready), 32'd0);
        check("m_out_data", 32'(out_data), 32'h01);
        tick();
        check("m_rem_nowrap", 32'(remaining), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("m_idle_busy", 32'(busy), 32'd0);
        check("m_idle_in_ready", 32'(in_ready), 32'd0);
        check("m_idle_rem", 32'(remaining), 32'd0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_checksum_ctrl.md
Name: xor_checksum_ctrl

Overview:
- Controller that sequences one shared WIDTH-bit Xor datapath to fold a burst of words into a single XOR checksum.
- Accepts a start command (seed, length).
- Consumes exactly that many words over a valid/ready input stream.
- Presents the result on a valid/ready output port.
- Sits between a word source (memory scanner or serial deframer) and a checker that compares checksums.

Parameters:
- WIDTH, 8: data word width in bits; also the width of the seed, accumulator and result.
- LEN_W, 8: width of the burst-length field; maximum burst is 2^LEN_W-1 words.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: command strobe; sampled only in IDLE.
- seed, input, WIDTH: initial accumulator value, captured with start.
- len, input, LEN_W: number of words in the burst, captured with start.
- busy, output, 1: high whenever state is not IDLE.
- in_valid, input, 1: source has a word on in_data.
- in_data, input, WIDTH: word to fold into the checksum.
- in_ready, output, 1: controller accepts a word this cycle.
- remaining, output, LEN_W: words still to be consumed.
- out_valid, output, 1: checksum available.
- out_data, output, WIDTH: checksum value.
- out_ready, input, 1: consumer accepts the checksum.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of current state (including mid-burst or while out_valid is high):
  - state=IDLE, acc=0, remaining=0
  - busy=0, in_ready=0, out_valid=0, out_data=0
  - No partial result is emitted after reset.
- State machine: IDLE, ACCUM, DONE. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 loads acc<=seed and remaining<=len.
  - Next state is ACCUM if len!=0, DONE if len==0 (result = seed).
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready. On a transfer, acc<=acc^in_data (Xor datapath, WIDTH bits, no carry) and remaining<=remaining-1.
  - If a transfer occurs while remaining==1, next state is DONE. The last word is therefore folded in the same edge as the transition.
  - A cycle with in_valid=0 is a stall: no change.
- DONE:
  - out_valid=1, out_data=acc. out_data is held stable while out_valid=1 && out_ready=0.
  - out_ready=1 returns the FSM to IDLE at the next edge.
  - No new start is taken in the same cycle; next start is accepted in IDLE.
- start is ignored while busy=1. The captured seed and len are not disturbed.
- Latency:
  - First word may be accepted in the cycle after start.
  - With continuous in_valid, out_valid rises the cycle after the last transfer.
  - Total start-to-out_valid is len+1 cycles (1 cycle for len=0).
- remaining never wraps: no decrement occurs at 0, because ACCUM is never entered with 0.
- in_data is don't-care when in_valid=0. Words presented outside ACCUM are not consumed.
- out_data reflects acc in all states. It is only meaningful when out_valid=1.

Test Plan:
- Reset then idle, WIDTH=8:
  - Stimulus: rst_n low 2 cycles, then high; start=0.
  - Response: busy=0, in_ready=0, out_valid=0, out_data=0x00, remaining=0 every cycle.
- Basic burst:
  - Stimulus: start with seed=0x00, len=3; words 0x0F, 0xF0, 0xAA with in_valid held high.
  - Response: three transfers on consecutive cycles; remaining 3→2→1→0; out_valid high at cycle 4 after start with out_data=0x55; out_ready=1 returns to IDLE next cycle.
- Zero length with back-pressure:
  - Stimulus: start with seed=0x3C, len=0; out_ready=0 for 3 cycles, then 1.
  - Response: out_valid=1 in the cycle after start; out_data=0x3C held for 3 cycles; IDLE after the handshake.
- Stalls and ignored start:
  - Stimulus: seed=0xFF, len=2; in_valid pattern 0,1,0,0,1 with words 0x01, 0x02; start=1 pulsed mid-burst with len=5.
  - Response: only 2 transfers; mid-burst start has no effect; out_data=0xFC.
- Reset mid-operation:
  - Stimulus: len=4; assert rst_n=0 after 2 transfers.
  - Response: next cycle IDLE, busy=0, out_valid=0, acc=0.
  - Follow-up: a new start with seed=0x11, len=1 and word 0x22 yields out_data=0x33.
- Max length:
  - Stimulus: len=255, all words 0x01, seed=0x00.
  - Response: remaining counts down to 0 with no wrap; out_data=0x01 (odd count); 255 transfers exactly, then in_ready=0.
